// File: rtl/ifid_skid_reg_pkg.sv
// Shared IF/ID pipeline types: default entry layout, NOP encoding and buffer occupancy states.
package ifid_skid_reg_pkg;

  localparam int unsigned IFID_XLEN = 32;
  localparam int unsigned IFID_ILEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [IFID_XLEN-1:0] pc;
    logic [IFID_ILEN-1:0] inst;
    logic                 pred;
  } ifid_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } ifid_state_t;

endpackage

// File: rtl/ifid_skid_reg_pipe_slot.sv
// Enable-gated register holding one IF/ID entry, with a per-instance reset value.
module pipe_slot
  import ifid_skid_reg_pkg::*;
#(
  parameter type    entry_t = ifid_entry_t,
  parameter entry_t RST_VAL = '0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  entry_t d,
  output entry_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifid_skid_reg.sv
// IF/ID boundary register: ready/valid handshake, two-entry skid buffer, flush bubble, stall counter.
module ifid_skid_reg
  import ifid_skid_reg_pkg::*;
#(
  parameter int unsigned      XLEN  = 32,
  parameter int unsigned      ILEN  = 32,
  parameter logic [ILEN-1:0]  NOP   = ILEN'(NOP_INST),
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [ILEN-1:0]  in_inst,
  input  logic             in_pred,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [ILEN-1:0]  out_inst,
  output logic             out_pred,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            pred;
  } entry_t;

  localparam entry_t          MAIN_RST = '{pc: '0, inst: NOP, pred: 1'b0};
  localparam entry_t          SKID_RST = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ifid_state_t state;
  ifid_state_t state_d;
  entry_t      in_ent;
  entry_t      main_q;
  entry_t      main_d;
  entry_t      skid_q;
  entry_t      bubble;
  logic        main_en;
  logic        skid_en;
  logic        acc_in;
  logic        acc_out;

  assign acc_in  = in_valid & in_ready;
  assign acc_out = out_valid & out_ready;
  assign in_ent  = '{pc: in_pc, inst: in_inst, pred: in_pred};
  // An empty head keeps its PC but shows a NOP, so out_inst/out_pred need no output mux.
  assign bubble  = '{pc: main_q.pc, inst: NOP, pred: 1'b0};

  // Occupancy transitions and slot load steering.
  always_comb begin
    state_d = state;
    main_en = 1'b0;
    main_d  = in_ent;
    skid_en = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (acc_in) begin
          state_d = ST_ONE;
          main_en = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc_in && !acc_out) begin
          state_d = ST_FULL;
          skid_en = 1'b1;
        end else if (acc_in) begin
          main_en = 1'b1;
        end else if (acc_out) begin
          state_d = ST_EMPTY;
          main_en = 1'b1;
          main_d  = bubble;
        end
      end
      ST_FULL: begin
        if (acc_out) begin
          state_d = ST_ONE;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b1;
      main_d  = bubble;
      skid_en = 1'b0;
    end
  end

  // Handshake flags are decoded from the next state so both ports stay purely registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d != ST_FULL);
      out_valid <= (state_d != ST_EMPTY);
      if (in_valid && !in_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  pipe_slot #(.entry_t(entry_t), .RST_VAL(MAIN_RST)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_slot #(.entry_t(entry_t), .RST_VAL(SKID_RST)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_ent),
    .q   (skid_q)
  );

  assign out_pc   = main_q.pc;
  assign out_inst = main_q.inst;
  assign out_pred = main_q.pred;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: directed scenarios plus random traffic against a queue-based reference model.
module tb_ifid_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_inst;
  logic          in_pred;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_pred;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  ifid_skid_reg #(.XLEN(32), .ILEN(32), .NOP(NOP), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_pred   (in_pred),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_pred  (out_pred),
    .stall_cnt (stall_cnt)
  );

  // Reference model: a FIFO of at most two entries, plus the PC the head last showed.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_last_pc;
  int          m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last_pc = '0;
    m_cnt     = 0;
  endtask

  task automatic model_step();
    ent_t e;
    bit   rdy;
    bit   acc_in;
    bit   acc_out;
    rdy     = (mq.size() < 2);
    acc_in  = in_valid && rdy;
    acc_out = (mq.size() > 0) && out_ready;
    if (in_valid && !rdy && m_cnt < (1 << CW) - 1) m_cnt++;
    if (flush) begin
      if (mq.size() > 0) m_last_pc = mq[0].pc;
      mq.delete();
    end else begin
      if (acc_out) begin
        e = mq.pop_front();
        m_last_pc = e.pc;
      end
      if (acc_in) begin
        e.pc = in_pc; e.inst = in_inst; e.pred = in_pred;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_all();
    bit          nonempty;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_pred;
    nonempty = (mq.size() > 0);
    exp_pc   = nonempty ? mq[0].pc   : m_last_pc;
    exp_inst = nonempty ? mq[0].inst : NOP;
    exp_pred = nonempty ? mq[0].pred : 1'b0;
    check("in_ready",  64'(in_ready),  64'(mq.size() < 2));
    check("out_valid", 64'(out_valid), 64'(nonempty));
    check("out_pc",    64'(out_pc),    64'(exp_pc));
    check("out_inst",  64'(out_inst),  64'(exp_inst));
    check("out_pred",  64'(out_pred),  64'(exp_pred));
    check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, then sample at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic pred, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    in_pred   = pred;
    out_ready = ordy;
    flush     = fl;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    in_pred = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_inst", 64'(out_inst), 64'(NOP));

    // First transfer: one-cycle latency from EMPTY.
    cycle(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b1, 1'b0);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_pc",    64'(out_pc),    64'h100);
    check("first_inst",  64'(out_inst),  64'h0050_0093);

    // Back-to-back stream with no backpressure.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'h1000 + 32'(4 * i), $urandom, 1'($urandom), 1'b1, 1'b0);
      check("stream_pc",    64'(out_pc),    64'(32'h1000 + 32'(4 * i)));
      check("stream_stall", 64'(stall_cnt), 64'd0);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Skid absorbs the transfer in flight when out_ready drops.
    cycle(1'b1, 32'h200, 32'h0010_0113, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h204, 32'h0020_0193, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head_pc",  64'(out_pc),   64'h200);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    check("drain_pc",       64'(out_pc),   64'h204);
    check("drain_in_ready", 64'(in_ready), 64'd1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Flush in FULL with a coincident offer: everything is dropped.
    cycle(1'b1, 32'h208, 32'h0030_0213, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h20c, 32'h0040_0293, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h300, 32'h0050_0313, 1'b1, 1'b1, 1'b1);
    check("flush_valid",    64'(out_valid), 64'd0);
    check("flush_inst",     64'(out_inst),  64'(NOP));
    check("flush_in_ready", 64'(in_ready),  64'd1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    check("flush_no_300", 64'(out_valid), 64'd0);

    // Persistent backpressure saturates the stall counter.
    repeat (22) cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'b0, 1'b0);
    check("stall_sat", 64'(stall_cnt), 64'd15);
    repeat (2) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    check("stall_hold", 64'(stall_cnt), 64'd15);

    // Asynchronous reset between edges while holding one entry.
    cycle(1'b1, 32'h400, 32'h0060_0393, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready),  64'd1);
    check("arst_pc",    64'(out_pc),    64'd0);
    check("arst_inst",  64'(out_inst),  64'(NOP));
    check("arst_pred",  64'(out_pred),  64'd0);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    cycle(1'b1, 32'h500, 32'h0070_0413, 1'b1, 1'b1, 1'b0);
    check("post_rst_pc",    64'(out_pc),    64'h500);
    check("post_rst_valid", 64'(out_valid), 64'd1);

    // Random traffic against the model.
    repeat (400) begin
      cycle(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
